// File: rtl/dmem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Package     : dmem_responder_pkg
// Description : Shared definitions for the MEM-stage data-memory responder.
//               Holds the RV32I funct3 width/sign codes, the FSM state type,
//               the byte-enable and wait-counter widths, and small helper
//               functions for the error check, store lane handling and load
//               formatting.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_responder_pkg;

    localparam int XLEN   = 32;
    localparam int BE_W   = XLEN / 8;
    localparam int WCNT_W = 4;   // wait counter covers WAIT_CYCLES 0..15

    // RV32I funct3 width/sign codes (loads and stores share 0..2)
    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    // Illegal width code for the direction, or an access that is not
    // naturally aligned. Legal halfword codes (1, 5) have funct3[1:0]=01 and
    // the word code has 10, so alignment is decided from the low two bits
    // once the code itself is known to be legal.
    function automatic logic request_error(input logic       we,
                                           input logic [2:0] f3,
                                           input logic [1:0] a);
        logic bad_code;
        logic misaligned;
        if (we) begin
            bad_code = (f3 != F3_B) && (f3 != F3_H) && (f3 != F3_W);
        end else begin
            bad_code = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
        end
        misaligned = ((f3[1:0] == 2'b01) && a[0]) ||
                     ((f3[1:0] == 2'b10) && (a != 2'b00));
        return bad_code || misaligned;
    endfunction

    function automatic logic [BE_W-1:0] store_byte_enable(input logic [2:0] f3,
                                                          input logic [1:0] a);
        logic [BE_W-1:0] be;
        unique case (f3[1:0])
            2'b00:   be = 4'b0001 << a;
            2'b01:   be = 4'b0011 << a;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate the store operand across all lanes so the byte enables alone
    // pick the destination bytes.
    function automatic logic [XLEN-1:0] store_replicate(input logic [XLEN-1:0] d,
                                                        input logic [2:0]      f3);
        logic [XLEN-1:0] r;
        unique case (f3[1:0])
            2'b00:   r = {4{d[7:0]}};
            2'b01:   r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic logic [XLEN-1:0] format_load(input logic [XLEN-1:0] raw,
                                                    input logic [1:0]      a,
                                                    input logic [2:0]      f3);
        logic [XLEN-1:0] sh;
        logic [XLEN-1:0] r;
        sh = raw >> {a, 3'b000};
        unique case (f3)
            F3_B:    r = {{24{sh[7]}}, sh[7:0]};
            F3_BU:   r = {24'd0, sh[7:0]};
            F3_H:    r = {{16{sh[15]}}, sh[15:0]};
            F3_HU:   r = {16'd0, sh[15:0]};
            default: r = raw;
        endcase
        return r;
    endfunction

endpackage : dmem_responder_pkg
`default_nettype wire

// File: rtl/dmem_sram.sv
`default_nettype none
// ============================================================================
// Module      : dmem_sram
// Description : Single-port 2**DEPTH_LOG2 x 32 SRAM with per-byte write
//               enables, synchronous write and one-cycle synchronous read.
//               Contents are not reset.
// Ports       : clk     - clock, rising edge
//               en_i    - access strobe for this edge
//               we_i    - 1 = write enabled bytes, 0 = read word
//               be_i    - byte enables (write only)
//               addr_i  - word index
//               wdata_i - write data (already lane-replicated)
//               rdata_o - read data, valid the cycle after a read edge
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_sram
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  en_i,
    input  logic                  we_i,
    input  logic [BE_W-1:0]       be_i,
    input  logic [DEPTH_LOG2-1:0] addr_i,
    input  logic [XLEN-1:0]       wdata_i,
    output logic [XLEN-1:0]       rdata_o
);

    logic [XLEN-1:0] mem_q [2**DEPTH_LOG2];
    logic [XLEN-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                for (int i = 0; i < BE_W; i++) begin
                    if (be_i[i]) begin
                        mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                    end
                end
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule : dmem_sram
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : MEM-stage data-memory responder. Accepts one load/store per
//               WAIT_CYCLES+2 cycles, performs the byte/half/word access on
//               an internal byte-enable SRAM and returns formatted load data.
// Ports       : clk, rst_n      - clock, asynchronous active-low reset
//               req_valid_i     - request present
//               req_we_i        - 1 = store, 0 = load
//               req_funct3_i    - RV32I width/sign code
//               req_addr_i      - byte address
//               req_wdata_i     - store data
//               req_ready_o     - request accepted when valid & ready
//               rsp_valid_o     - one-cycle completion pulse
//               rsp_rdata_o     - formatted load data (0 for stores/errors)
//               rsp_err_o       - misaligned or illegal funct3
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid_i,
    input  logic            req_we_i,
    input  logic [2:0]      req_funct3_i,
    input  logic [XLEN-1:0] req_addr_i,
    input  logic [XLEN-1:0] req_wdata_i,
    output logic            req_ready_o,
    output logic            rsp_valid_o,
    output logic [XLEN-1:0] rsp_rdata_o,
    output logic            rsp_err_o
);

    localparam int AW = DEPTH_LOG2 + 2;   // byte address bits that reach the SRAM
    localparam logic [WCNT_W-1:0] WAIT_LOAD =
        (WAIT_CYCLES > 0) ? WCNT_W'(WAIT_CYCLES - 1) : '0;

    state_e            state_q;
    logic [WCNT_W-1:0] wcnt_q;
    logic              rsp_valid_q;

    // Latched request
    logic [AW-1:0]     addr_q;
    logic              we_q;
    logic [2:0]        funct3_q;
    logic [XLEN-1:0]   wdata_q;
    logic              err_q;

    // Response values kept after RESP so the outputs stay stable
    logic [XLEN-1:0]   rdata_hold_q;
    logic              err_hold_q;

    logic              w_accept;
    logic              w_req_err;
    logic              w_sram_en;
    logic [XLEN-1:0]   w_sram_rdata;
    logic [XLEN-1:0]   w_rsp_rdata;
    logic              w_in_resp;

    // Address bits above the SRAM range alias by design.
    logic              unused_addr_hi;
    assign unused_addr_hi = ^req_addr_i[XLEN-1:AW];

    assign req_ready_o = (state_q == ST_IDLE) || (state_q == ST_RESP);
    assign w_accept    = req_valid_i && req_ready_o;
    assign w_req_err   = request_error(req_we_i, req_funct3_i, req_addr_i[1:0]);
    assign w_in_resp   = (state_q == ST_RESP);

    // ------------------------------------------------------------------
    // FSM + wait counter. Errored requests go straight to RESP and never
    // touch the SRAM.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            wcnt_q      <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            unique case (state_q)
                ST_IDLE, ST_RESP: begin
                    state_q <= ST_IDLE;
                    if (w_accept) begin
                        if (w_req_err) begin
                            state_q     <= ST_RESP;
                            rsp_valid_q <= 1'b1;
                        end else if (WAIT_CYCLES > 0) begin
                            state_q <= ST_WAIT;
                            wcnt_q  <= WAIT_LOAD;
                        end else begin
                            state_q <= ST_ACCESS;
                        end
                    end
                end
                ST_WAIT: begin
                    if (wcnt_q == '0) begin
                        state_q <= ST_ACCESS;
                    end else begin
                        wcnt_q <= wcnt_q - WCNT_W'(1);
                    end
                end
                ST_ACCESS: begin
                    state_q     <= ST_RESP;
                    rsp_valid_q <= 1'b1;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Request latch and response hold registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q       <= '0;
            we_q         <= 1'b0;
            funct3_q     <= '0;
            wdata_q      <= '0;
            err_q        <= 1'b0;
            rdata_hold_q <= '0;
            err_hold_q   <= 1'b0;
        end else begin
            // Hold capture uses the outgoing request, before any new accept
            // in the same RESP cycle overwrites the latch.
            if (w_in_resp) begin
                rdata_hold_q <= w_rsp_rdata;
                err_hold_q   <= err_q;
            end
            if (w_accept) begin
                addr_q   <= req_addr_i[AW-1:0];
                we_q     <= req_we_i;
                funct3_q <= req_funct3_i;
                wdata_q  <= req_wdata_i;
                err_q    <= w_req_err;
            end
        end
    end

    // ------------------------------------------------------------------
    // SRAM: accessed only on the ACCESS edge, so a reset earlier in the
    // request drops it without a write.
    // ------------------------------------------------------------------
    assign w_sram_en = (state_q == ST_ACCESS);

    dmem_sram #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_sram (
        .clk     (clk),
        .en_i    (w_sram_en),
        .we_i    (we_q),
        .be_i    (store_byte_enable(funct3_q, addr_q[1:0])),
        .addr_i  (addr_q[AW-1:2]),
        .wdata_i (store_replicate(wdata_q, funct3_q)),
        .rdata_o (w_sram_rdata)
    );

    // SRAM read data arrives in RESP; format it there.
    assign w_rsp_rdata = (err_q || we_q) ? '0
                       : format_load(w_sram_rdata, addr_q[1:0], funct3_q);

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = w_in_resp ? w_rsp_rdata : rdata_hold_q;
    assign rsp_err_o   = w_in_resp ? err_q       : err_hold_q;

endmodule : dmem_responder
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Directed self-checking bench. Three responder instances with
//               WAIT_CYCLES = 0, 3 and 2 share clock and reset; each is
//               driven through its own request lane.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    localparam int DEPTH_LOG2 = 10;
    localparam int N_DUT      = 3;
    localparam int MAX_WAIT   = 40;

    logic        clk;
    logic        rst_n;
    logic [N_DUT-1:0] vld;
    logic [N_DUT-1:0] we;
    logic [2:0]  f3    [N_DUT];
    logic [31:0] addr  [N_DUT];
    logic [31:0] wdata [N_DUT];
    logic [N_DUT-1:0] rdy;
    logic [N_DUT-1:0] rvld;
    logic [31:0] rdata [N_DUT];
    logic [N_DUT-1:0] rerr;

    int n_checks;
    int n_errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_LOG2(DEPTH_LOG2), .WAIT_CYCLES(0)) u_dut_w0 (
        .clk(clk), .rst_n(rst_n), .req_valid_i(vld[0]), .req_we_i(we[0]),
        .req_funct3_i(f3[0]), .req_addr_i(addr[0]), .req_wdata_i(wdata[0]),
        .req_ready_o(rdy[0]), .rsp_valid_o(rvld[0]), .rsp_rdata_o(rdata[0]),
        .rsp_err_o(rerr[0]));

    dmem_responder #(.DEPTH_LOG2(DEPTH_LOG2), .WAIT_CYCLES(3)) u_dut_w3 (
        .clk(clk), .rst_n(rst_n), .req_valid_i(vld[1]), .req_we_i(we[1]),
        .req_funct3_i(f3[1]), .req_addr_i(addr[1]), .req_wdata_i(wdata[1]),
        .req_ready_o(rdy[1]), .rsp_valid_o(rvld[1]), .rsp_rdata_o(rdata[1]),
        .rsp_err_o(rerr[1]));

    dmem_responder #(.DEPTH_LOG2(DEPTH_LOG2), .WAIT_CYCLES(2)) u_dut_w2 (
        .clk(clk), .rst_n(rst_n), .req_valid_i(vld[2]), .req_we_i(we[2]),
        .req_funct3_i(f3[2]), .req_addr_i(addr[2]), .req_wdata_i(wdata[2]),
        .req_ready_o(rdy[2]), .rsp_valid_o(rvld[2]), .rsp_rdata_o(rdata[2]),
        .rsp_err_o(rerr[2]));

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One complete request on lane k. Returns the response, the cycle
    // offset of rsp_valid relative to the accept cycle A, and req_ready as
    // seen in cycle A+1. Inputs are scrambled after the accept so the
    // design must work from its latched copy.
    task automatic mem_op(input int k, input logic w, input logic [2:0] fn,
                          input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic er,
                          output int lat, output logic rdy_a1);
        int guard;
        @(negedge clk);
        vld[k] = 1'b1; we[k] = w; f3[k] = fn; addr[k] = a; wdata[k] = d;
        guard = 0;
        while (!rdy[k] && guard < MAX_WAIT) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        @(negedge clk);
        vld[k] = 1'b0; we[k] = ~w; f3[k] = 3'd7; addr[k] = ~a; wdata[k] = ~d;
        rdy_a1 = rdy[k];
        lat = 1;
        while (!rvld[k] && lat < MAX_WAIT) begin
            @(negedge clk);
            lat++;
        end
        if (!rvld[k]) check_eq("rsp_timeout", 32'(rvld[k]), 32'd1);
        rd = rdata[k];
        er = rerr[k];
        @(negedge clk);
        check_eq("rsp_pulse_len", 32'(rvld[k]), 32'd0);
    endtask

    // Directed vectors: lane, we, funct3, addr, wdata, exp rdata, exp err, exp latency
    typedef struct {
        string       tag;
        int          k;
        logic        w;
        logic [2:0]  fn;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_rd;
        logic        exp_er;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        logic        r1;
        int          acc_cyc [3];
        int          rsp_cyc [3];
        logic [31:0] rsp_dat [3];
        int          n_acc;
        int          n_rsp;
        logic        pending;
        logic [31:0] seq_a [3];
        logic        seq_w [3];

        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        for (int k = 0; k < N_DUT; k++) begin
            vld[k] = 1'b0; we[k] = 1'b0; f3[k] = 3'd0; addr[k] = '0; wdata[k] = '0;
        end

        // Reset state
        repeat (3) @(negedge clk);
        for (int k = 0; k < N_DUT; k++) begin
            check_eq($sformatf("rst_valid%0d", k), 32'(rvld[k]), 32'd0);
            check_eq($sformatf("rst_rdata%0d", k), rdata[k], 32'd0);
            check_eq($sformatf("rst_err%0d", k),   32'(rerr[k]), 32'd0);
            check_eq($sformatf("rst_ready%0d", k), 32'(rdy[k]), 32'd1);
        end
        rst_n = 1'b1;

        // Mid-WAIT reset on the WAIT_CYCLES=3 instance
        mem_op(1, 1'b1, 3'd2, 32'h40, 32'h1122_3344, rd, er, lat, r1);
        check_eq("w3_sw_lat", 32'(lat), 32'd5);
        mem_op(1, 1'b0, 3'd2, 32'h40, 32'h0, rd, er, lat, r1);
        check_eq("w3_lw_data", rd, 32'h1122_3344);
        check_eq("w3_lw_lat", 32'(lat), 32'd5);
        @(negedge clk);
        vld[1] = 1'b1; we[1] = 1'b1; f3[1] = 3'd2; addr[1] = 32'h40; wdata[1] = 32'hCAFE_F00D;
        @(posedge clk);
        @(negedge clk);
        vld[1] = 1'b0;
        check_eq("w3_ready_in_wait", 32'(rdy[1]), 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_valid", 32'(rvld[1]), 32'd0);
        check_eq("midrst_rdata", rdata[1], 32'd0);
        check_eq("midrst_err",   32'(rerr[1]), 32'd0);
        check_eq("midrst_ready", 32'(rdy[1]), 32'd1);
        repeat (5) @(negedge clk);
        check_eq("midrst_valid_hold", 32'(rvld[1]), 32'd0);
        rst_n = 1'b1;
        mem_op(1, 1'b0, 3'd2, 32'h40, 32'h0, rd, er, lat, r1);
        check_eq("midrst_word_kept", rd, 32'h1122_3344);

        // SW/LW with WAIT_CYCLES=0: latency and ready low in ACCESS
        mem_op(0, 1'b1, 3'd2, 32'h100, 32'hDEAD_BEEF, rd, er, lat, r1);
        check_eq("sw_lat", 32'(lat), 32'd2);
        check_eq("sw_ready_access", 32'(r1), 32'd0);
        check_eq("sw_rdata", rd, 32'd0);
        check_eq("sw_err", 32'(er), 32'd0);

        vecs = '{
            '{"lw_100",      0, 1'b0, 3'd2, 32'h100, 32'h0,         32'hDEAD_BEEF, 1'b0, 2},
            '{"sw_200",      0, 1'b1, 3'd2, 32'h200, 32'h1122_3344, 32'h0,         1'b0, 2},
            '{"sb_201",      0, 1'b1, 3'd0, 32'h201, 32'hAAAA_AA80, 32'h0,         1'b0, 2},
            '{"lb_201",      0, 1'b0, 3'd0, 32'h201, 32'h0,         32'hFFFF_FF80, 1'b0, 2},
            '{"lbu_201",     0, 1'b0, 3'd4, 32'h201, 32'h0,         32'h0000_0080, 1'b0, 2},
            '{"lw_200",      0, 1'b0, 3'd2, 32'h200, 32'h0,         32'h1122_8044, 1'b0, 2},
            '{"sw_300",      0, 1'b1, 3'd2, 32'h300, 32'h5566_7788, 32'h0,         1'b0, 2},
            '{"sh_302",      0, 1'b1, 3'd1, 32'h302, 32'h1234_8001, 32'h0,         1'b0, 2},
            '{"lh_302",      0, 1'b0, 3'd1, 32'h302, 32'h0,         32'hFFFF_8001, 1'b0, 2},
            '{"lhu_302",     0, 1'b0, 3'd5, 32'h302, 32'h0,         32'h0000_8001, 1'b0, 2},
            '{"lw_300",      0, 1'b0, 3'd2, 32'h300, 32'h0,         32'h8001_7788, 1'b0, 2},
            '{"lb_203",      0, 1'b0, 3'd0, 32'h203, 32'h0,         32'h0000_0011, 1'b0, 2},
            '{"err_lw_102",  0, 1'b0, 3'd2, 32'h102, 32'h0,         32'h0,         1'b1, 1},
            '{"err_sh_101",  0, 1'b1, 3'd1, 32'h101, 32'hFFFF_FFFF, 32'h0,         1'b1, 1},
            '{"err_s_f3_3",  0, 1'b1, 3'd3, 32'h100, 32'h0,         32'h0,         1'b1, 1},
            '{"err_l_f3_6",  0, 1'b0, 3'd6, 32'h100, 32'h0,         32'h0,         1'b1, 1},
            '{"lw_100_kept", 0, 1'b0, 3'd2, 32'h100, 32'h0,         32'hDEAD_BEEF, 1'b0, 2}
        };
        foreach (vecs[i]) begin
            mem_op(vecs[i].k, vecs[i].w, vecs[i].fn, vecs[i].a, vecs[i].d, rd, er, lat, r1);
            check_eq({vecs[i].tag, "_rdata"}, rd, vecs[i].exp_rd);
            check_eq({vecs[i].tag, "_err"}, 32'(er), 32'(vecs[i].exp_er));
            check_eq({vecs[i].tag, "_lat"}, 32'(lat), 32'(vecs[i].exp_lat));
        end

        // Held outputs outside RESP: last response was DEADBEEF
        check_eq("hold_rdata", rdata[0], 32'hDEAD_BEEF);

        // Back-to-back with valid held on the WAIT_CYCLES=2 instance
        seq_w = '{1'b1, 1'b0, 1'b0};
        seq_a = '{32'h10, 32'h10 + 32'(4 * (2 ** DEPTH_LOG2)), 32'h10};
        n_acc = 0;
        n_rsp = 0;
        pending = 1'b0;
        @(negedge clk);
        vld[2] = 1'b1; we[2] = seq_w[0]; f3[2] = 3'd2; addr[2] = seq_a[0];
        wdata[2] = 32'hA5A5_5A5A;
        for (int c = 0; c < MAX_WAIT && n_rsp < 3; c++) begin
            if (c > 0) @(negedge clk);
            if (pending) begin
                pending = 1'b0;
                if (n_acc < 3) begin
                    we[2] = seq_w[n_acc]; addr[2] = seq_a[n_acc]; wdata[2] = 32'h0;
                end else begin
                    vld[2] = 1'b0;
                end
            end
            if (rvld[2]) begin
                rsp_dat[n_rsp] = rdata[2];
                rsp_cyc[n_rsp] = c;
                n_rsp++;
            end
            if (vld[2] && rdy[2]) begin
                acc_cyc[n_acc] = c;
                n_acc++;
                pending = 1'b1;
            end
        end
        vld[2] = 1'b0;
        check_eq("b2b_n_accept", 32'(n_acc), 32'd3);
        check_eq("b2b_n_rsp", 32'(n_rsp), 32'd3);
        if (n_acc == 3 && n_rsp == 3) begin
            check_eq("b2b_gap01", 32'(acc_cyc[1] - acc_cyc[0]), 32'd4);
            check_eq("b2b_gap12", 32'(acc_cyc[2] - acc_cyc[1]), 32'd4);
            for (int i = 0; i < 3; i++) begin
                check_eq($sformatf("b2b_lat%0d", i), 32'(rsp_cyc[i] - acc_cyc[i]), 32'd4);
            end
            check_eq("b2b_sw_rdata", rsp_dat[0], 32'h0);
            check_eq("b2b_alias_rdata", rsp_dat[1], 32'hA5A5_5A5A);
            check_eq("b2b_lw_rdata", rsp_dat[2], 32'hA5A5_5A5A);
        end

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_dmem_responder
`default_nettype wire
